// File: rtl/usb_rx_ctrl_pkg.sv
// rtl/usb_rx_ctrl_pkg.sv - shared types and constants for the USB RX control unit
package usb_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RCV_SYNC = 3'd1,
    RCV_DATA = 3'd2,
    EOP_WAIT = 3'd3,
    ERR_WAIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SYNC    = 2'd1,
    ERR_PARTIAL = 2'd2,
    ERR_OVF     = 2'd3
  } err_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'b1000_0000;

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// rtl/usb_rx_ctrl_if.sv - line-side inputs and FIFO-side outputs of the RX control unit
interface usb_rx_ctrl_if #(
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 7
);
  logic              d_edge;
  logic              eop;
  logic              shift_enable;
  logic [BYTE_W-1:0] rcv_data;
  logic              byte_received;
  logic              rcving;
  logic              w_enable;
  logic              r_error;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  byte_cnt;
  logic              pkt_done;

  modport slave (
    input  d_edge, eop, shift_enable, rcv_data, byte_received,
    output rcving, w_enable, r_error, err_code, byte_cnt, pkt_done
  );

  modport master (
    output d_edge, eop, shift_enable, rcv_data, byte_received,
    input  rcving, w_enable, r_error, err_code, byte_cnt, pkt_done
  );
endinterface

// File: rtl/usb_rx_ctrl_flex_counter.sv
// rtl/usb_rx_ctrl_flex_counter.sv - clearable up-counter used for the packet byte count
module usb_rx_ctrl_flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clear,
  input  logic             i_count_enable,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - sequences one USB packet: SYNC check, data bytes to FIFO, EOP detection
module usb_rx_ctrl
  import usb_rx_ctrl_pkg::*;
#(
  parameter int                BYTE_W    = 8,
  parameter logic [BYTE_W-1:0] SYNC_PAT  = BYTE_W'(SYNC_DEFAULT),
  parameter int                MAX_BYTES = 64,
  parameter int                EOP_BITS  = 2,
  parameter int                CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input logic          clk,
  input logic          n_rst,
  usb_rx_ctrl_if.slave bus
);
  localparam int               EC_W     = $clog2(EOP_BITS + 1);
  localparam logic [EC_W-1:0]  EOP_LAST = EC_W'(EOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BYTES);

  state_t           r_state, w_state_nxt, w_mid;
  err_t             r_err_code, w_err_code;
  logic             r_partial, r_rcving, r_w_enable, r_error, r_pkt_done;
  logic [EC_W-1:0]  r_eop_cnt;
  logic [CNT_W-1:0] w_byte_cnt;
  logic             w_se_eop, w_se_line, w_eop_done, w_partial_eff, w_start;
  logic             w_write, w_err_set, w_done, w_rcving_nxt;

  assign w_se_eop      = bus.shift_enable & bus.eop;
  assign w_se_line     = bus.shift_enable & ~bus.eop;
  assign w_eop_done    = w_se_eop && (r_eop_cnt == EOP_LAST);
  assign w_partial_eff = r_partial & ~bus.byte_received;
  assign w_start       = (r_state == IDLE) && bus.d_edge;

  usb_rx_ctrl_flex_counter #(.WIDTH(CNT_W)) u_byte_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_start),
    .i_count_enable (w_write),
    .o_count        (w_byte_cnt)
  );

  // A received byte is resolved first (w_mid); a coincident EOP strobe then acts on that state.
  always_comb begin
    w_mid        = r_state;
    w_state_nxt  = r_state;
    w_write      = 1'b0;
    w_err_set    = 1'b0;
    w_err_code   = ERR_NONE;
    w_done       = 1'b0;
    w_rcving_nxt = r_rcving;

    case (r_state)
      IDLE: begin
        if (bus.d_edge) begin
          w_mid        = RCV_SYNC;
          w_rcving_nxt = 1'b1;
        end
      end
      RCV_SYNC: begin
        if (bus.byte_received) begin
          if (bus.rcv_data == SYNC_PAT) begin
            w_mid = RCV_DATA;
          end else begin
            w_mid      = ERR_WAIT;
            w_err_set  = 1'b1;
            w_err_code = ERR_SYNC;
          end
        end
      end
      RCV_DATA: begin
        if (bus.byte_received) begin
          if (w_byte_cnt < CNT_MAX) begin
            w_write = 1'b1;
          end else begin
            w_mid      = ERR_WAIT;
            w_err_set  = 1'b1;
            w_err_code = ERR_OVF;
          end
        end
      end
      default: ;
    endcase

    w_state_nxt = w_mid;
    if (r_state != IDLE) begin
      if (w_se_eop) begin
        case (w_mid)
          RCV_SYNC: begin
            w_state_nxt = ERR_WAIT;
            w_err_set   = 1'b1;
            w_err_code  = ERR_PARTIAL;
          end
          RCV_DATA: begin
            if (w_partial_eff) begin
              w_state_nxt = ERR_WAIT;
              w_err_set   = 1'b1;
              w_err_code  = ERR_PARTIAL;
            end else begin
              w_state_nxt = EOP_WAIT;
            end
          end
          default: ;
        endcase
        if (w_eop_done) begin
          w_done       = (w_state_nxt == EOP_WAIT);
          w_state_nxt  = IDLE;
          w_rcving_nxt = 1'b0;
        end
      end else if (w_se_line && (w_mid == EOP_WAIT)) begin
        w_state_nxt = ERR_WAIT;
        w_err_set   = 1'b1;
        w_err_code  = ERR_PARTIAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_rcving   <= 1'b0;
      r_w_enable <= 1'b0;
      r_pkt_done <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_eop_cnt  <= '0;
      r_partial  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rcving   <= w_rcving_nxt;
      r_w_enable <= w_write;
      r_pkt_done <= w_done;

      // The first error of a packet wins; only a new packet start clears it.
      if (w_start) begin
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
      end else if (w_err_set && !r_error) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_code;
      end

      if (w_start || w_se_line) begin
        r_eop_cnt <= '0;
      end else if (w_se_eop) begin
        r_eop_cnt <= w_eop_done ? '0 : r_eop_cnt + 1'b1;
      end

      if (w_start || bus.byte_received) begin
        r_partial <= 1'b0;
      end else if (w_se_line) begin
        r_partial <= 1'b1;
      end
    end
  end

  assign bus.rcving   = r_rcving;
  assign bus.w_enable = r_w_enable;
  assign bus.r_error  = r_error;
  assign bus.err_code = r_err_code;
  assign bus.byte_cnt = w_byte_cnt;
  assign bus.pkt_done = r_pkt_done;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb/tb_usb_rx_ctrl.sv - randomized packet bench for usb_rx_ctrl with a packet-level reference model
`timescale 1ns/1ps
module tb_usb_rx_ctrl;
  localparam int         BYTE_W    = 8;
  localparam int         MAX_BYTES = 4;
  localparam int         EOP_BITS  = 2;
  localparam int         CNT_W     = 3;
  localparam logic [7:0] SYNC      = 8'h80;

  localparam int P_OFF = 0, P_SYNC = 1, P_BODY = 2, P_TAIL = 3, P_BAD = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_ctrl_if #(.BYTE_W(BYTE_W), .CNT_W(CNT_W)) bus ();

  usb_rx_ctrl #(
    .BYTE_W(BYTE_W), .SYNC_PAT(SYNC), .MAX_BYTES(MAX_BYTES),
    .EOP_BITS(EOP_BITS), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wen = 0;
  int   n_done = 0;
  bit   cmp_on = 1'b0;
  logic line_eop = 1'b0;

  int   m_phase = P_OFF;
  int   m_bits = 0;
  int   m_se0 = 0;
  int   exp_cnt = 0;
  int   exp_code = 0;
  logic exp_rcving = 1'b0;
  logic exp_wen = 1'b0;
  logic exp_err = 1'b0;
  logic exp_done = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_fail(input int code);
    if (!exp_err) begin
      exp_err  = 1'b1;
      exp_code = code;
    end
    m_phase = P_BAD;
  endtask

  // Reference model: one packet described by phase, line-bit count since the last byte and SE0 run length.
  always @(posedge clk) begin
    logic se_eop, se_line, partial_before;
    se_eop  = bus.shift_enable & bus.eop;
    se_line = bus.shift_enable & ~bus.eop;
    partial_before = (m_bits > 0) && !bus.byte_received;
    if (!n_rst) begin
      m_phase = P_OFF; m_bits = 0; m_se0 = 0; exp_cnt = 0; exp_code = 0;
      exp_rcving = 0; exp_wen = 0; exp_err = 0; exp_done = 0;
    end else begin
      exp_wen  = 0;
      exp_done = 0;
      if (m_phase == P_OFF) begin
        if (bus.d_edge) begin
          m_phase = P_SYNC; exp_rcving = 1; exp_err = 0; exp_code = 0;
          exp_cnt = 0; m_bits = 0; m_se0 = 0;
        end
      end else begin
        if (bus.byte_received) begin
          if (m_phase == P_SYNC) begin
            if (bus.rcv_data == SYNC) m_phase = P_BODY;
            else m_fail(1);
          end else if (m_phase == P_BODY) begin
            if (exp_cnt < MAX_BYTES) begin
              exp_cnt++;
              exp_wen = 1;
            end else begin
              m_fail(3);
            end
          end
        end
        if (se_eop) begin
          m_se0++;
          if (m_phase == P_SYNC) m_fail(2);
          else if (m_phase == P_BODY) begin
            if (partial_before) m_fail(2);
            else m_phase = P_TAIL;
          end
          if (m_se0 == EOP_BITS) begin
            if (m_phase == P_TAIL) exp_done = 1;
            m_phase = P_OFF; exp_rcving = 0; m_se0 = 0;
          end
        end else if (se_line) begin
          m_se0 = 0;
          if (m_phase == P_TAIL) m_fail(2);
        end
        if (bus.byte_received) m_bits = 0;
        else if (se_line) m_bits++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("rcving",   8'(bus.rcving),   8'(exp_rcving));
      chk("w_enable", 8'(bus.w_enable), 8'(exp_wen));
      chk("r_error",  8'(bus.r_error),  8'(exp_err));
      chk("err_code", 8'(bus.err_code), 8'(exp_code));
      chk("byte_cnt", 8'(bus.byte_cnt), 8'(exp_cnt));
      chk("pkt_done", 8'(bus.pkt_done), 8'(exp_done));
      if (bus.w_enable === 1'b1) n_wen++;
      if (bus.pkt_done === 1'b1) n_done++;
    end
  end

  task automatic drive(input logic se, input logic e, input logic br, input logic [7:0] d, input logic de);
    bus.shift_enable  = se;
    bus.eop           = e;
    bus.byte_received = br;
    bus.rcv_data      = d;
    bus.d_edge        = de;
    @(posedge clk);
    #1;
    bus.shift_enable  = 1'b0;
    bus.byte_received = 1'b0;
    bus.d_edge        = 1'b0;
    bus.eop           = line_eop;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) drive(1'b0, line_eop, 1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send_bits(input int n, input bit nz);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'($urandom), nz && ($urandom_range(0, 15) == 0));
      gap();
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(7, 1'b1);
    if ($urandom_range(0, 1) == 1) begin
      drive(1'b1, 1'b0, 1'b1, d, 1'b0);
    end else begin
      drive(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
      gap();
      drive(1'b0, 1'b0, 1'b1, d, 1'b0);
    end
    gap();
  endtask

  task automatic send_eop(input int n, input bit br_first);
    line_eop = 1'b1;
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b1, br_first && (k == 0), 8'($urandom), 1'b0);
      gap();
    end
    line_eop = 1'b0;
    bus.eop  = 1'b0;
  endtask

  task automatic pkt(input logic [7:0] sync, input int nbytes, input int pbits, input int eoplen, input bit coinc);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    gap();
    send_byte(sync);
    for (int i = 0; i < nbytes - (coinc ? 1 : 0); i++) send_byte(8'($urandom));
    if (coinc) send_bits(8, 1'b0);
    send_bits(pbits, 1'b0);
    send_eop(eoplen, coinc);
    if (eoplen < EOP_BITS) begin
      send_bits(1, 1'b0);
      send_eop(EOP_BITS, 1'b0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #3_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

  initial begin
    int w0, d0, nb, pb, el;
    bit co;
    logic [7:0] sy;
    bus.d_edge = 0; bus.eop = 0; bus.shift_enable = 0; bus.rcv_data = 0; bus.byte_received = 0;
    @(posedge clk);
    #1;
    cmp_on = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("reset_rcving",   8'(bus.rcving),   8'd0);
    chk("reset_err",      8'(bus.r_error),  8'd0);
    chk("reset_byte_cnt", 8'(bus.byte_cnt), 8'd0);

    w0 = n_wen; d0 = n_done;
    pkt(SYNC, 2, 0, 2, 1'b0);
    chk("good_writes",   8'(n_wen - w0),    8'd2);
    chk("good_done",     8'(n_done - d0),   8'd1);
    chk("good_byte_cnt", 8'(bus.byte_cnt),  8'd2);
    chk("good_err",      8'(bus.r_error),   8'd0);
    chk("good_rcving",   8'(bus.rcving),    8'd0);

    w0 = n_wen; d0 = n_done;
    pkt(8'h81, 2, 0, 2, 1'b0);
    chk("badsync_writes", 8'(n_wen - w0),    8'd0);
    chk("badsync_err",    8'(bus.r_error),   8'd1);
    chk("badsync_code",   8'(bus.err_code),  8'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("restart_err",    8'(bus.r_error),   8'd0);
    chk("restart_rcving", 8'(bus.rcving),    8'd1);
    send_eop(EOP_BITS, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    w0 = n_wen; d0 = n_done;
    pkt(SYNC, 1, 3, 2, 1'b0);
    chk("partial_writes", 8'(n_wen - w0),   8'd1);
    chk("partial_code",   8'(bus.err_code), 8'd2);
    chk("partial_done",   8'(n_done - d0),  8'd0);

    w0 = n_wen;
    pkt(SYNC, 5, 0, 2, 1'b0);
    chk("ovf_writes",   8'(n_wen - w0),    8'd4);
    chk("ovf_code",     8'(bus.err_code),  8'd3);
    chk("ovf_byte_cnt", 8'(bus.byte_cnt),  8'd4);

    w0 = n_wen; d0 = n_done;
    pkt(SYNC, 2, 0, 2, 1'b1);
    chk("coinc_writes", 8'(n_wen - w0),   8'd2);
    chk("coinc_done",   8'(n_done - d0),  8'd1);
    chk("coinc_err",    8'(bus.r_error),  8'd0);

    w0 = n_wen;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_bits(3, 1'b0);
    n_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_rcving",   8'(bus.rcving),   8'd0);
    chk("rst_wen",      8'(bus.w_enable), 8'd0);
    chk("rst_byte_cnt", 8'(bus.byte_cnt), 8'd0);
    n_rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_writes", 8'(n_wen - w0), 8'd2);

    for (int p = 0; p < 40; p++) begin
      sy = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SYNC;
      nb = $urandom_range(0, 6);
      pb = ($urandom_range(0, 4) < 3) ? 0 : $urandom_range(1, 7);
      el = $urandom_range(1, 3);
      co = (nb > 0) && ($urandom_range(0, 3) == 0);
      pkt(sy, nb, pb, el, co);
    end
    send_eop(EOP_BITS, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    summary();
    $finish;
  end
endmodule
